// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the lab RAM controller: state encodings, default widths
// and small helpers describing what each state does to the RAM pins.
package ram_ctrl_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_SETUP  = 3'd1,
        W_STROBE = 3'd2,
        W_HOLD   = 3'd3,
        R_ACCESS = 3'd4,
        V_TURN   = 3'd5,
        V_ACCESS = 3'd6
    } state_t;

    // The wait counter holds (cycles - 1), so it only needs to reach max-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic st_drives(input state_t s);
        return (s == W_SETUP) || (s == W_STROBE) || (s == W_HOLD);
    endfunction

    function automatic logic st_reads(input state_t s);
        return (s == R_ACCESS) || (s == V_ACCESS);
    endfunction

endpackage

// File: rtl/ram_ctrl_wait_cnt.sv
// Loadable down-counter with a zero flag; times the setup, read and verify waits.
module ram_ctrl_wait_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/ram_ctrl.sv
// Registered pin sequencer for the async lab RAM with a valid/ready host port.
// Optional write read-back check enabled by defining RAM_CTRL_WRVERIFY_EN.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SETUP_CYC = 1,
    parameter int READ_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs_n,
    output logic              ram_oe,
    output logic              ram_ws,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam int CNT_W = cnt_width(SETUP_CYC, READ_WAIT);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT - 1);

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  wdata_reg;
    logic               drive_reg;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;
    logic               done_next;
    logic               rd_sample;
    logic               accept;

    ram_ctrl_wait_cnt #(.W(CNT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid && req_ready;
    assign ram_data  = drive_reg ? wdata_reg : {DATA_W{1'bz}};

`ifdef RAM_CTRL_WRVERIFY_EN
    logic vf_sample;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        done_next  = 1'b0;
        rd_sample  = 1'b0;
`ifdef RAM_CTRL_WRVERIFY_EN
        vf_sample  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    cnt_load   = 1'b1;
                    cnt_val    = req_we ? SETUP_LOAD : READ_LOAD;
                    state_next = req_we ? W_SETUP : R_ACCESS;
                end
            end
            W_SETUP:  if (cnt_zero) state_next = W_STROBE;
            W_STROBE: state_next = W_HOLD;
            W_HOLD: begin
`ifdef RAM_CTRL_WRVERIFY_EN
                state_next = V_TURN;
`else
                state_next = IDLE;
                done_next  = 1'b1;
`endif
            end
            R_ACCESS: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    rd_sample  = 1'b1;
                end
            end
`ifdef RAM_CTRL_WRVERIFY_EN
            // One dead cycle with CS high so bus ownership changes cleanly.
            V_TURN: begin
                cnt_load   = 1'b1;
                cnt_val    = READ_LOAD;
                state_next = V_ACCESS;
            end
            V_ACCESS: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    vf_sample  = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Pins are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ram_cs_n  <= 1'b1;
            ram_oe    <= 1'b0;
            ram_ws    <= 1'b0;
            drive_reg <= 1'b0;
            ram_addr  <= '0;
            wdata_reg <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_reg <= state_next;
            ram_cs_n  <= !(st_drives(state_next) || st_reads(state_next));
            ram_oe    <= st_reads(state_next);
            ram_ws    <= (state_next == W_STROBE);
            drive_reg <= st_drives(state_next);
            rsp_valid <= done_next;
            if (accept) begin
                ram_addr  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (rd_sample) begin
                rsp_rdata <= ram_data;
            end
        end
    end

`ifdef RAM_CTRL_WRVERIFY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (done_next) begin
            rsp_err <= vf_sample && (ram_data != wdata_reg);
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: async RAM model, cycle-level transaction model
// and a per-cycle compare process, plus directed literal checks.
module tb_ram_ctrl;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int SETUP_CYC = 1;
    localparam int READ_WAIT = 2;
`ifdef RAM_CTRL_WRVERIFY_EN
    localparam bit VF = 1'b1;
`else
    localparam bit VF = 1'b0;
`endif
    localparam int LAT_W = VF ? (SETUP_CYC + 3 + READ_WAIT) : (SETUP_CYC + 2);
    localparam int LAT_R = READ_WAIT;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_cs_n;
    logic          ram_oe;
    logic          ram_ws;
    wire  [DW-1:0] ram_data;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    ram_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(SETUP_CYC), .READ_WAIT(READ_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_cs_n(ram_cs_n), .ram_oe(ram_oe),
        .ram_ws(ram_ws), .ram_data(ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Async RAM: drives the bus when selected and OE high, writes on WS rising edge.
    logic [DW-1:0] mem [32];
    logic          corrupt = 1'b0;
    int            ws_rises = 0;

    assign ram_data = (ram_oe && !ram_cs_n) ? mem[ram_addr] : {DW{1'bz}};

    always @(posedge ram_ws) begin
        mem[ram_addr] <= corrupt ? (ram_data ^ 8'h01) : ram_data;
        ws_rises      <= ws_rises + 1;
    end

    // Transaction model: remaining cycles of the current op and expected responses.
    int            rem = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_corrupt = 1'b0;
    logic          exp_valid = 1'b0;
    logic          exp_err = 1'b0;
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] shadow [32];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem       <= 0;
            exp_valid <= 1'b0;
            exp_rdata <= '0;
            exp_err   <= 1'b0;
        end else if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) begin
                exp_valid <= 1'b1;
                if (m_we) begin
                    shadow[m_addr] <= m_corrupt ? (m_wdata ^ 8'h01) : m_wdata;
                    exp_err        <= VF && m_corrupt;
                end else begin
                    exp_rdata <= shadow[m_addr];
                    exp_err   <= 1'b0;
                end
            end else begin
                exp_valid <= 1'b0;
            end
        end else begin
            exp_valid <= 1'b0;
            if (req_valid) begin
                rem       <= req_we ? LAT_W : LAT_R;
                m_we      <= req_we;
                m_addr    <= req_addr;
                m_wdata   <= req_wdata;
                m_corrupt <= corrupt;
            end
        end
    end

    // Expected pin levels from the elapsed phase of the current operation.
    function automatic void exp_pins(input int r, input bit we,
                                     output bit cs_n, output bit oe, output bit ws, output bit drv);
        int p;
        cs_n = 1'b1; oe = 1'b0; ws = 1'b0; drv = 1'b0;
        if (r != 0) begin
            if (we) begin
                p = LAT_W - r;
                if (p < SETUP_CYC) begin
                    cs_n = 1'b0; drv = 1'b1;
                end else if (p == SETUP_CYC) begin
                    cs_n = 1'b0; ws = 1'b1; drv = 1'b1;
                end else if (p == SETUP_CYC + 1) begin
                    cs_n = 1'b0; drv = 1'b1;
                end else if (p >= SETUP_CYC + 3) begin
                    cs_n = 1'b0; oe = 1'b1;
                end
            end else begin
                cs_n = 1'b0; oe = 1'b1;
            end
        end
    endfunction

    always @(negedge clk) begin
        bit e_cs_n, e_oe, e_ws, e_drv;
        if (!rst && mon_en) begin
            exp_pins(rem, m_we, e_cs_n, e_oe, e_ws, e_drv);
            chk("rsp_valid", rsp_valid, exp_valid);
            chk("req_ready", req_ready, rem == 0);
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            if (exp_valid) chk("rsp_err", rsp_err, exp_err);
            chk("ram_cs_n", ram_cs_n, e_cs_n);
            chk("ram_oe", ram_oe, e_oe);
            chk("ram_ws", ram_ws, e_ws);
            if (e_drv) begin
                chk("wr_bus", ram_data, m_wdata);
                chk("wr_addr", ram_addr, m_addr);
            end
            if (e_oe) begin
                chk("rd_bus", ram_data, mem[m_addr]);
                chk("rd_addr", ram_addr, m_addr);
            end
        end
    end

    task automatic scramble();
        req_we    = 1'b1;
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
    endtask

    task automatic op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit hold, output int lat, output logic [DW-1:0] rd);
        int guard = 0;
        while (rem != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        if (hold && !rsp_valid) scramble(); else req_valid = 1'b0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (hold && !rsp_valid) scramble(); else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
        rd = rsp_rdata;
    endtask

    initial begin
        int            lat;
        int            ws0;
        logic [DW-1:0] rd;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        for (int i = 0; i < 32; i++) begin
            mem[i]    = DW'(i * 7 + 1);
            shadow[i] = DW'(i * 7 + 1);
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_cs_n", ram_cs_n, 1);
        chk("rst_oe", ram_oe, 0);
        chk("rst_ws", ram_ws, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);

        // Basic write then read back
        ws0 = ws_rises;
        op(1'b1, 5'h03, 8'hA5, 1'b0, lat, rd);
        chk("wr_latency", lat, VF ? 6 : 3);
        chk("wr_ws_edges", ws_rises - ws0, 1);
        ws0 = ws_rises;
        op(1'b0, 5'h03, 8'h00, 1'b0, lat, rd);
        chk("rd_latency", lat, 2);
        chk("rd_data_A5", rd, 8'hA5);
        chk("rd_ws_edges", ws_rises - ws0, 0);

        // Back-to-back at the address extremes
        op(1'b1, 5'h1F, 8'h3C, 1'b0, lat, rd);
        op(1'b1, 5'h00, 8'hC3, 1'b0, lat, rd);
        chk("b2b_rdata_kept", rd, 8'hA5);
        op(1'b0, 5'h1F, 8'h00, 1'b0, lat, rd);
        chk("b2b_rd_1F", rd, 8'h3C);
        op(1'b0, 5'h00, 8'h00, 1'b0, lat, rd);
        chk("b2b_rd_00", rd, 8'hC3);

        // req_valid held while busy with changing fields
        op(1'b0, 5'h03, 8'h00, 1'b1, lat, rd);
        chk("hold_rd", rd, 8'hA5);
        op(1'b1, 5'h10, 8'h77, 1'b1, lat, rd);
        chk("hold_wr_keeps_rdata", rd, 8'hA5);
        op(1'b0, 5'h10, 8'h00, 1'b0, lat, rd);
        chk("hold_rd_10", rd, 8'h77);

`ifdef RAM_CTRL_WRVERIFY_EN
        corrupt = 1'b1;
        op(1'b1, 5'h05, 8'h5A, 1'b0, lat, rd);
        chk("vf_corrupt_err", rsp_err, 1);
        corrupt = 1'b0;
        op(1'b1, 5'h06, 8'h5A, 1'b0, lat, rd);
        chk("vf_ok_err", rsp_err, 0);
        chk("vf_latency", lat, SETUP_CYC + 3 + READ_WAIT);
`endif

        // Reset in the middle of W_SETUP
        op(1'b0, 5'h0A, 8'h00, 1'b0, lat, rd);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h0A; req_wdata = 8'h99;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", ram_cs_n, 1);
        chk("mid_rst_ws", ram_ws, 0);
        chk("mid_rst_oe", ram_oe, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", req_ready, 1);
        @(negedge clk);
        chk("post_rst_no_rsp", rsp_valid, 0);
        op(1'b0, 5'h0A, 8'h00, 1'b0, lat, rd);
        chk("abandoned_write", rd, 8'(10 * 7 + 1));

        // Random mix; the compare process checks every cycle
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom);
            a  = AW'($urandom);
            d  = DW'($urandom);
            ws0 = ws_rises;
            op(we, a, d, 1'b0, lat, rd);
            chk("rand_ws_edges", ws_rises - ws0, {31'd0, we});
            chk("rand_latency", lat, we ? LAT_W : LAT_R);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
